// File: rtl/div_job_sequencer.sv
// div_job_sequencer
// Accepts one division job at a time, feeds the operands to an external
// multi-cycle divider through its clear/start/data protocol, waits for the
// result (bounded by TIMEOUT cycles) and holds it until downstream takes it.
// A zero divisor never reaches the divider; the result is synthesised here.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            job handshake, operands in_dividend/in_divisor
//   div_clear, div_start, div_data divider control and operand bus
//   div_done, div_quotient/_remainder  divider completion and result
//   out_valid / out_ready          result handshake
//   out_quotient, out_remainder    held result
//   out_divzero, out_timeout       status of the held result
module div_job_sequencer #(
  parameter int TIMEOUT = 140000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_dividend,
  input  logic [15:0] in_divisor,
  output logic        div_clear,
  output logic        div_start,
  output logic [15:0] div_data,
  input  logic        div_done,
  input  logic [15:0] div_quotient,
  input  logic [15:0] div_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_quotient,
  output logic [15:0] out_remainder,
  output logic        out_divzero,
  output logic        out_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_LOAD_A = 3'd3;
  localparam logic [2:0] S_LOAD_B = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [15:0]   dividend_r;
  logic [15:0]   divisor_r;
  logic          accept_s;

  logic          in_ready_r;
  logic          out_valid_r;
  logic          div_clear_r;
  logic          div_start_r;
  logic [15:0]   div_data_r;
  logic [15:0]   div_data_nxt_s;
  logic [15:0]   out_quotient_r;
  logic [15:0]   out_remainder_r;
  logic          out_divzero_r;
  logic          out_timeout_r;

  logic          res_load_s;
  logic [15:0]   res_q_s;
  logic [15:0]   res_r_s;
  logic          res_dz_s;
  logic          res_to_s;

  assign accept_s = in_valid && (state_r == S_IDLE);

  // Next-state and result-capture decision
  always_comb begin
    state_nxt_s = state_r;
    res_load_s  = 1'b0;
    res_q_s     = out_quotient_r;
    res_r_s     = out_remainder_r;
    res_dz_s    = out_divzero_r;
    res_to_s    = out_timeout_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          if (in_divisor == 16'd0) begin
            // Divide-by-zero is answered locally without touching the divider
            state_nxt_s = S_RESULT;
            res_load_s  = 1'b1;
            res_q_s     = 16'hFFFF;
            res_r_s     = in_dividend;
            res_dz_s    = 1'b1;
            res_to_s    = 1'b0;
          end else begin
            state_nxt_s = S_CLEAR;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR:  state_nxt_s = S_START;
      S_START:  state_nxt_s = S_LOAD_A;
      S_LOAD_A: state_nxt_s = S_LOAD_B;
      S_LOAD_B: state_nxt_s = S_WAIT;
      S_WAIT: begin
        // A done on the last allowed cycle still counts as a real result
        if (div_done) begin
          state_nxt_s = S_RESULT;
          res_load_s  = 1'b1;
          res_q_s     = div_quotient;
          res_r_s     = div_remainder;
          res_dz_s    = 1'b0;
          res_to_s    = 1'b0;
        end else if (cnt_r == TMO_LAST) begin
          state_nxt_s = S_RESULT;
          res_load_s  = 1'b1;
          res_q_s     = 16'd0;
          res_r_s     = 16'd0;
          res_dz_s    = 1'b0;
          res_to_s    = 1'b1;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESULT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand bus value for the upcoming state
  always_comb begin
    div_data_nxt_s = 16'd0;
    case (state_nxt_s)
      S_START, S_LOAD_A: div_data_nxt_s = dividend_r;
      S_LOAD_B, S_WAIT:  div_data_nxt_s = divisor_r;
      default:           div_data_nxt_s = 16'd0;
    endcase
  end

  // State, counter, operands and registered outputs (decoded from next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      cnt_r           <= '0;
      dividend_r      <= 16'd0;
      divisor_r       <= 16'd0;
      in_ready_r      <= 1'b1;
      out_valid_r     <= 1'b0;
      div_clear_r     <= 1'b0;
      div_start_r     <= 1'b0;
      div_data_r      <= 16'd0;
      out_quotient_r  <= 16'd0;
      out_remainder_r <= 16'd0;
      out_divzero_r   <= 1'b0;
      out_timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == S_IDLE);
      out_valid_r <= (state_nxt_s == S_RESULT);
      div_clear_r <= (state_nxt_s == S_CLEAR);
      div_start_r <= (state_nxt_s == S_START);
      div_data_r  <= div_data_nxt_s;
      if ((state_r == S_WAIT) && (state_nxt_s == S_WAIT)) begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= '0;
      end
      if (accept_s) begin
        dividend_r <= in_dividend;
        divisor_r  <= in_divisor;
      end
      if (res_load_s) begin
        out_quotient_r  <= res_q_s;
        out_remainder_r <= res_r_s;
        out_divzero_r   <= res_dz_s;
        out_timeout_r   <= res_to_s;
      end
    end
  end

  assign in_ready      = in_ready_r;
  assign out_valid     = out_valid_r;
  assign div_clear     = div_clear_r;
  assign div_start     = div_start_r;
  assign div_data      = div_data_r;
  assign out_quotient  = out_quotient_r;
  assign out_remainder = out_remainder_r;
  assign out_divzero   = out_divzero_r;
  assign out_timeout   = out_timeout_r;

endmodule

// File: tb/tb_div_job_sequencer.sv
// Directed bench for div_job_sequencer. Two instances share the job inputs:
// dut uses the default TIMEOUT, dut_to uses TIMEOUT=20 for timeout cases.
module tb_div_job_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_dividend = 16'd0;
  logic [15:0] in_divisor = 16'd0;
  logic        div_done = 1'b0;
  logic        div_done_to = 1'b0;
  logic [15:0] div_quotient = 16'd0;
  logic [15:0] div_remainder = 16'd0;
  logic        out_ready = 1'b0;

  logic        in_ready, div_clear, div_start, out_valid, out_divzero, out_timeout;
  logic [15:0] div_data, out_quotient, out_remainder;
  logic        t_in_ready, t_div_clear, t_div_start, t_out_valid, t_out_divzero, t_out_timeout;
  logic [15:0] t_div_data, t_out_quotient, t_out_remainder;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_job_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_clear(div_clear), .div_start(div_start), .div_data(div_data),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_divzero(out_divzero), .out_timeout(out_timeout)
  );

  div_job_sequencer #(.TIMEOUT(20)) dut_to (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_clear(t_div_clear), .div_start(t_div_start), .div_data(t_div_data),
    .div_done(div_done_to), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(t_out_valid), .out_ready(out_ready),
    .out_quotient(t_out_quotient), .out_remainder(t_out_remainder),
    .out_divzero(t_out_divzero), .out_timeout(t_out_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state
    rst = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_clear", div_clear, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_data", div_data, 0);
    chk("rst_quot", out_quotient, 0);
    chk("rst_rem", out_remainder, 0);
    chk("rst_flags", {out_divzero, out_timeout}, 0);
    rst = 1'b0;
    step();

    // ---------------- job 100/7, divider answers 14/2 in 30th WAIT cycle
    in_valid = 1'b1; in_dividend = 16'd100; in_divisor = 16'd7;
    chk("j1_idle_in_ready", in_ready, 1);
    step();                                   // CLEAR
    in_valid = 1'b0;
    chk("j1_clear", div_clear, 1);
    chk("j1_clear_start", div_start, 0);
    chk("j1_clear_in_ready", in_ready, 0);
    step();                                   // START
    chk("j1_start_clear", div_clear, 0);
    chk("j1_start", div_start, 1);
    chk("j1_start_data", div_data, 100);
    step();                                   // LOAD_A
    chk("j1_loada_start", div_start, 0);
    chk("j1_loada_data", div_data, 100);
    step();                                   // LOAD_B
    chk("j1_loadb_data", div_data, 7);
    step();                                   // WAIT cnt 0
    chk("j1_wait_data", div_data, 7);
    chk("j1_wait_start", div_start, 0);
    for (int i = 0; i < 29; i++) step();
    chk("j1_wait_still", out_valid, 0);
    chk("j1_wait_data_hold", div_data, 7);
    div_done = 1'b1; div_quotient = 16'd14; div_remainder = 16'd2;
    step();                                   // RESULT
    div_done = 1'b0; div_quotient = 16'hAAAA; div_remainder = 16'h5555;
    chk("j1_out_valid", out_valid, 1);
    chk("j1_quot", out_quotient, 14);
    chk("j1_rem", out_remainder, 2);
    chk("j1_flags", {out_divzero, out_timeout}, 0);
    chk("j1_res_data", div_data, 0);

    // ---------------- hold result 10 cycles with out_ready low
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_result", {out_quotient, out_remainder}, {16'd14, 16'd2});
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_dividend = 16'd55; in_divisor = 16'd0;
    #1;
    chk("res_ordy_in_ready", in_ready, 0);
    step();                                   // IDLE
    out_ready = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_div_data", div_data, 0);

    // ---------------- divide by zero 55/0
    step();                                   // RESULT directly
    in_valid = 1'b0;
    chk("dz_out_valid", out_valid, 1);
    chk("dz_quot", out_quotient, 16'hFFFF);
    chk("dz_rem", out_remainder, 55);
    chk("dz_flags", {out_divzero, out_timeout}, 2'b10);
    chk("dz_no_clear", div_clear, 0);
    chk("dz_no_start", div_start, 0);
    chk("dz_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("dz_back_idle", in_ready, 1);

    // ---------------- timeout (TIMEOUT=20), divider silent
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b1; in_dividend = 16'd11; in_divisor = 16'd3;
    step(); in_valid = 1'b0;                  // CLEAR
    step(); step(); step(); step();           // START, LOAD_A, LOAD_B, WAIT cnt 0
    chk("to_wait_data", t_div_data, 3);
    for (int i = 0; i < 19; i++) step();      // WAIT cnt 19
    chk("to_not_yet", t_out_valid, 0);
    step();
    chk("to_out_valid", t_out_valid, 1);
    chk("to_quot", t_out_quotient, 0);
    chk("to_rem", t_out_remainder, 0);
    chk("to_flags", {t_out_divzero, t_out_timeout}, 2'b01);

    // ---------------- reset in the middle of WAIT
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b1; in_dividend = 16'd200; in_divisor = 16'd9;
    step(); in_valid = 1'b0;
    step(); step(); step(); step();           // WAIT cnt 0
    for (int i = 0; i < 5; i++) step();
    chk("mid_wait_data", div_data, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ctrl", {div_clear, div_start}, 0);
    chk("mid_rst_data", div_data, 0);
    step();
    chk("mid_rst_no_result", out_valid, 0);
    in_valid = 1'b1; in_dividend = 16'd9; in_divisor = 16'd3;
    step(); in_valid = 1'b0;                  // CLEAR
    chk("j3_clear", {div_clear, div_start}, 2'b10);
    step();
    chk("j3_start", {div_clear, div_start}, 2'b01);
    chk("j3_start_data", div_data, 9);
    step(); step(); step();                   // LOAD_A, LOAD_B, WAIT
    chk("j3_wait_data", div_data, 3);
    div_done = 1'b1; div_quotient = 16'd3; div_remainder = 16'd0;
    step();
    div_done = 1'b0;
    chk("j3_out_valid", out_valid, 1);
    chk("j3_result", {out_quotient, out_remainder}, {16'd3, 16'd0});
    chk("j3_flags", {out_divzero, out_timeout}, 0);

    // ---------------- done during LOAD_A ignored, done on final count wins
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b1; in_dividend = 16'd50; in_divisor = 16'd5;
    step(); in_valid = 1'b0;                  // CLEAR
    step(); step();                           // START, LOAD_A
    div_done_to = 1'b1; div_quotient = 16'd99; div_remainder = 16'd99;
    step();                                   // LOAD_B
    div_done_to = 1'b0;
    chk("ld_ignore_valid", t_out_valid, 0);
    chk("ld_ignore_data", t_div_data, 5);
    step();                                   // WAIT cnt 0
    for (int i = 0; i < 19; i++) step();      // WAIT cnt 19
    chk("fin_not_yet", t_out_valid, 0);
    div_done_to = 1'b1; div_quotient = 16'd10; div_remainder = 16'd0;
    step();
    div_done_to = 1'b0;
    chk("fin_out_valid", t_out_valid, 1);
    chk("fin_result", {t_out_quotient, t_out_remainder}, {16'd10, 16'd0});
    chk("fin_flags", {t_out_divzero, t_out_timeout}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
